// File: rtl/h264_pkg.sv
// rtl/h264_pkg.sv - shared types and helpers for the H.264 chroma reconstruction path
package h264_pkg;

  localparam logic [7:0] CHROMA_DC_DEFAULT = 8'h80;

  typedef logic [3:0][8:0] resid_row_t;
  typedef logic [3:0][7:0] pix_row_t;

  typedef enum logic {
    FB_IDLE = 1'b0,
    FB_EMIT = 1'b1
  } fb_state_t;

  // Input range is base(0..255) + residual(-256..255), so bit 9 flags negative, bit 8 flags >255.
  function automatic logic [7:0] clip_u8(input logic [9:0] s);
    if (s[9]) return 8'h00;
    if (s[8]) return 8'hFF;
    return s[7:0];
  endfunction

endpackage

// File: rtl/h264_chroma_recon_if.sv
// rtl/h264_chroma_recon_if.sv - predictor/transform side bus of the chroma reconstruction block
interface h264_chroma_recon_if;

  logic        NEWLINE;
  logic        BSTROBEI;
  logic [7:0]  BASEI;
  logic        STROBEI;
  logic [35:0] DATAI;
  logic        READYI;
  logic        STROBEO;
  logic [31:0] DATAO;
  logic        FBSTROBE;
  logic [7:0]  FEEDBO;
  logic        ERRO;

  modport master (
    output NEWLINE, BSTROBEI, BASEI, STROBEI, DATAI,
    input  READYI, STROBEO, DATAO, FBSTROBE, FEEDBO, ERRO
  );

  modport slave (
    input  NEWLINE, BSTROBEI, BASEI, STROBEI, DATAI,
    output READYI, STROBEO, DATAO, FBSTROBE, FEEDBO, ERRO
  );

endinterface

// File: rtl/h264_base_fifo.sv
// rtl/h264_base_fifo.sv - DC base FIFO, one entry per 4x4 block; a pop frees room for a same-cycle push
module h264_base_fifo #(
  parameter int BDEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam int AW = $clog2(BDEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(BDEPTH);

  logic [7:0]    mem [BDEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/h264_chroma_recon.sv
// rtl/h264_chroma_recon.sv - adds DC base to residual rows, clips to 8 bits, and feeds the
// right-hand column of each 4x4 block back to the predictor through two ping-pong buffers
module h264_chroma_recon #(
  parameter int BDEPTH = 4
) (
  input logic CLK2,
  input logic RESETN,
  h264_chroma_recon_if.slave bus
);
  import h264_pkg::*;

  logic            nl, row_strobe, base_push;
  logic            fifo_pop, fifo_full, fifo_empty, fifo_ovf;
  logic [7:0]      fifo_head, base_sel;
  logic [1:0]      rowcnt, s1_row;
  resid_row_t      resid;
  logic [3:0][9:0] sum_c, s1_sum;
  pix_row_t        pix_c, datao_q;
  logic            s1_valid, strobeo_q, erro_q, ready_en;

  logic [1:0][3:0][7:0] fb_buf;
  logic [1:0]           fb_full;
  logic                 wbuf, rbuf, rbuf_nxt, tgt;
  logic [1:0]           bcnt, bcnt_nxt;
  fb_state_t            state, state_nxt;
  logic                 fb_wr, emit_last, fb_clobber, fbstrobe;
  logic [7:0]           feedbo;

  // NEWLINE outranks any strobe seen in the same cycle
  assign nl         = bus.NEWLINE;
  assign row_strobe = bus.STROBEI && !nl;
  assign base_push  = bus.BSTROBEI && !nl;
  assign fifo_pop   = row_strobe && (rowcnt == 2'd3) && !fifo_empty;
  assign base_sel   = fifo_empty ? CHROMA_DC_DEFAULT : fifo_head;
  assign resid      = bus.DATAI;

  h264_base_fifo #(.BDEPTH(BDEPTH)) u_base_fifo (
    .clk   (CLK2),
    .rst_n (RESETN),
    .flush (nl),
    .push  (base_push),
    .pop   (fifo_pop),
    .wdata (bus.BASEI),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ovf   (fifo_ovf)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum_c[i] = {2'b00, base_sel} + {resid[i][8], resid[i]};
      pix_c[i] = clip_u8(s1_sum[i]);
    end
  end

  always_ff @(posedge CLK2 or negedge RESETN) begin
    if (!RESETN) begin
      rowcnt    <= '0;
      s1_valid  <= 1'b0;
      s1_row    <= '0;
      s1_sum    <= '0;
      strobeo_q <= 1'b0;
      datao_q   <= '0;
      erro_q    <= 1'b0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (nl) begin
        rowcnt    <= '0;
        s1_valid  <= 1'b0;
        strobeo_q <= 1'b0;
      end else begin
        s1_valid  <= row_strobe;
        strobeo_q <= s1_valid;
        if (row_strobe) begin
          rowcnt <= rowcnt + 2'd1;
          s1_row <= rowcnt;
          s1_sum <= sum_c;
        end
        if (s1_valid) datao_q <= pix_c;
      end
      if (fifo_ovf || (row_strobe && fifo_empty) || fb_clobber) erro_q <= 1'b1;
    end
  end

  // A block landing while both buffers are full must not touch the one being emitted
  assign fb_wr      = s1_valid && !nl;
  assign emit_last  = (state == FB_EMIT) && (bcnt == 2'd3);
  assign tgt        = ((state == FB_EMIT) && (rbuf == wbuf) && !emit_last) ? ~wbuf : wbuf;
  assign fb_clobber = fb_wr && (s1_row == 2'd3) && fb_full[tgt] && !(emit_last && (rbuf == tgt));

  always_ff @(posedge CLK2 or negedge RESETN) begin
    if (!RESETN) begin
      fb_buf  <= '0;
      fb_full <= '0;
      wbuf    <= 1'b0;
    end else if (nl) begin
      fb_full <= '0;
      wbuf    <= 1'b0;
    end else begin
      if (emit_last) fb_full[rbuf] <= 1'b0;
      if (fb_wr) begin
        fb_buf[tgt][s1_row] <= pix_c[3];
        if (s1_row == 2'd3) begin
          fb_full[tgt] <= 1'b1;
          wbuf         <= ~tgt;
        end
      end
    end
  end

  always_ff @(posedge CLK2 or negedge RESETN) begin
    if (!RESETN) begin
      state <= FB_IDLE;
      rbuf  <= 1'b0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      rbuf  <= rbuf_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rbuf_nxt  = rbuf;
    bcnt_nxt  = bcnt;
    if (nl) begin
      state_nxt = FB_IDLE;
      bcnt_nxt  = '0;
    end else begin
      case (state)
        FB_IDLE: begin
          if (|fb_full) begin
            state_nxt = FB_EMIT;
            rbuf_nxt  = fb_full[~wbuf] ? ~wbuf : wbuf;
            bcnt_nxt  = '0;
          end
        end
        FB_EMIT: begin
          bcnt_nxt = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            if (fb_full[~rbuf]) rbuf_nxt = ~rbuf;
            else                state_nxt = FB_IDLE;
          end
        end
        default: state_nxt = FB_IDLE;
      endcase
    end
  end

  always_comb begin
    fbstrobe = (state == FB_EMIT);
    feedbo   = fbstrobe ? fb_buf[rbuf][bcnt] : 8'h00;
  end

  assign bus.READYI   = ready_en && !fifo_full;
  assign bus.STROBEO  = strobeo_q;
  assign bus.DATAO    = datao_q;
  assign bus.FBSTROBE = fbstrobe;
  assign bus.FEEDBO   = feedbo;
  assign bus.ERRO     = erro_q;

endmodule

// File: tb/tb_h264_chroma_recon.sv
// tb/tb_h264_chroma_recon.sv - directed scoreboard bench for h264_chroma_recon
module tb_h264_chroma_recon;

  logic CLK2 = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK2 = ~CLK2;

  h264_chroma_recon_if bus();

  h264_chroma_recon #(.BDEPTH(4)) dut (
    .CLK2   (CLK2),
    .RESETN (RESETN),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_row_t;

  exp_row_t    row_q[$];
  logic [7:0]  fb_q[$];
  logic [7:0]  mfifo[$];
  logic [7:0]  blk_p3[4];
  int          mrow = 0;
  logic        merr = 1'b0;
  int          cyc = 0;
  int          n_checks = 0, n_pass = 0, n_fail = 0;
  int          fb_seen = 0, fb_first = 0, fb_last = 0;

  always @(posedge CLK2) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expix(input int b, input int r);
    int s;
    s = b + r;
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hFF;
    return s[7:0];
  endfunction

  always @(negedge CLK2) begin
    exp_row_t e;
    if (bus.STROBEO === 1'b1) begin
      if (row_q.size() == 0) check("row_unexpected", {31'b0, bus.STROBEO}, 32'd0);
      else begin
        e = row_q.pop_front();
        check("row_data", bus.DATAO, e.data);
        check("row_latency", cyc, e.cyc);
      end
    end
    if (bus.FBSTROBE === 1'b1) begin
      if (fb_seen == 0) fb_first = cyc;
      fb_last = cyc;
      fb_seen++;
      if (fb_q.size() == 0) check("fb_unexpected", {31'b0, bus.FBSTROBE}, 32'd0);
      else check("fb_byte", {24'b0, bus.FEEDBO}, {24'b0, fb_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK2);
    #1;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mfifo.size() < 4) mfifo.push_back(b);
    else merr = 1'b1;
  endtask

  task automatic push_base(input logic [7:0] b);
    model_push(b);
    bus.BSTROBEI = 1'b1;
    bus.BASEI    = b;
    tick(1);
    bus.BSTROBEI = 1'b0;
  endtask

  task automatic drive_row(input int r3, input int r2, input int r1, input int r0,
                           input bit pb = 1'b0, input int b = 0);
    int          base;
    logic [31:0] px;
    logic [7:0]  bb;
    exp_row_t    e;
    bb = b[7:0];
    if (mfifo.size() == 0) begin
      base = 128;
      merr = 1'b1;
    end else base = int'(mfifo[0]);
    px = {expix(base, r3), expix(base, r2), expix(base, r1), expix(base, r0)};
    if (mrow == 3 && mfifo.size() != 0) void'(mfifo.pop_front());
    if (pb) model_push(bb);
    blk_p3[mrow] = px[31:24];
    if (mrow == 3) for (int k = 0; k < 4; k++) fb_q.push_back(blk_p3[k]);
    mrow = (mrow + 1) % 4;
    e.data = px;
    e.cyc  = cyc + 2;
    row_q.push_back(e);
    bus.STROBEI  = 1'b1;
    bus.DATAI    = {9'(r3), 9'(r2), 9'(r1), 9'(r0)};
    bus.BSTROBEI = pb;
    bus.BASEI    = bb;
    tick(1);
    bus.STROBEI  = 1'b0;
    bus.BSTROBEI = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((row_q.size() != 0 || fb_q.size() != 0) && w < 60) begin
      tick(1);
      w++;
    end
    tick(2);
    check("drain_rows", row_q.size(), 0);
    check("drain_fb", fb_q.size(), 0);
  endtask

  initial begin
    int w;
    bus.NEWLINE  = 1'b0;
    bus.BSTROBEI = 1'b0;
    bus.BASEI    = '0;
    bus.STROBEI  = 1'b0;
    bus.DATAI    = '0;

    // reset state
    tick(3);
    check("rst_strobeo", {31'b0, bus.STROBEO}, 0);
    check("rst_datao", bus.DATAO, 0);
    check("rst_fbstrobe", {31'b0, bus.FBSTROBE}, 0);
    check("rst_feedbo", {24'b0, bus.FEEDBO}, 0);
    check("rst_erro", {31'b0, bus.ERRO}, 0);
    check("rst_readyi", {31'b0, bus.READYI}, 0);
    RESETN = 1'b1;
    tick(2);
    check("readyi_idle", {31'b0, bus.READYI}, 1);

    // 1: base 80 + 5
    push_base(8'h80);
    for (int i = 0; i < 4; i++) drive_row(5, 5, 5, 5);
    drain();
    check("t1_erro", {31'b0, bus.ERRO}, {31'b0, merr});

    // 2: saturation both ways
    push_base(8'hF0);
    drive_row(20, -256, 15, 0);
    for (int i = 0; i < 3; i++) drive_row(0, 0, 0, 0);
    drain();

    // 3: back-to-back blocks, feedback bursts with no gap
    push_base(8'd10);
    push_base(8'd20);
    fb_seen = 0;
    for (int i = 0; i < 8; i++) drive_row(0, 0, 0, 0);
    drain();
    check("t3_fb_count", fb_seen, 8);
    check("t3_fb_span", fb_last - fb_first, 7);
    check("t3_erro", {31'b0, bus.ERRO}, {31'b0, merr});

    // 4: fill FIFO, overflow drop, push+pop while full, then underflow
    push_base(8'd30);
    push_base(8'd40);
    push_base(8'd50);
    push_base(8'd60);
    check("t4_readyi_full", {31'b0, bus.READYI}, 0);
    check("t4_erro_before", {31'b0, bus.ERRO}, 0);
    push_base(8'd70);
    check("t4_erro_ovf", {31'b0, bus.ERRO}, {31'b0, merr});
    for (int blk = 0; blk < 6; blk++) begin
      for (int r = 0; r < 4; r++) begin
        if (blk == 0 && r == 3) begin
          drive_row(100, -100, 1, -1, 1'b1, 90);
          check("t4_readyi_pushpop", {31'b0, bus.READYI}, 0);
        end else drive_row(100, -100, 1 + r, -1 - blk);
      end
    end
    drain();
    check("t4_erro", {31'b0, bus.ERRO}, {31'b0, merr});

    // 5: NEWLINE during second byte of a burst, with ignored strobes
    push_base(8'h33);
    for (int i = 0; i < 4; i++) drive_row(2, 2, 2, 2);
    w = 0;
    while (bus.FBSTROBE !== 1'b1 && w < 30) begin
      @(negedge CLK2);
      w++;
    end
    check("t5_fb_start", {31'b0, bus.FBSTROBE}, 1);
    @(posedge CLK2);
    #1;
    bus.NEWLINE  = 1'b1;
    bus.STROBEI  = 1'b1;
    bus.DATAI    = '0;
    bus.BSTROBEI = 1'b1;
    bus.BASEI    = 8'h55;
    tick(1);
    bus.NEWLINE  = 1'b0;
    bus.STROBEI  = 1'b0;
    bus.BSTROBEI = 1'b0;
    fb_q.delete();
    mfifo.delete();
    mrow = 0;
    check("t5_fb_abort", {31'b0, bus.FBSTROBE}, 0);
    check("t5_readyi", {31'b0, bus.READYI}, 1);
    tick(2);
    check("t5_fb_quiet", {31'b0, bus.FBSTROBE}, 0);
    push_base(8'h44);
    for (int i = 0; i < 4; i++) drive_row(1, 1, 1, 1);
    drain();

    // 6: reset mid-block and mid-burst
    push_base(8'h50);
    push_base(8'h60);
    for (int i = 0; i < 6; i++) drive_row(3, 3, 3, 3);
    RESETN = 1'b0;
    #1;
    check("t6_strobeo", {31'b0, bus.STROBEO}, 0);
    check("t6_datao", bus.DATAO, 0);
    check("t6_fbstrobe", {31'b0, bus.FBSTROBE}, 0);
    check("t6_feedbo", {24'b0, bus.FEEDBO}, 0);
    check("t6_erro", {31'b0, bus.ERRO}, 0);
    check("t6_readyi", {31'b0, bus.READYI}, 0);
    row_q.delete();
    fb_q.delete();
    mfifo.delete();
    mrow = 0;
    merr = 1'b0;
    tick(2);
    RESETN = 1'b1;
    tick(2);
    check("t6_readyi_rel", {31'b0, bus.READYI}, 1);
    push_base(8'h70);
    drive_row(-5, 10, -200, 100);
    for (int i = 0; i < 3; i++) drive_row(7, -7, 0, 0);
    drain();
    check("t6_erro_clean", {31'b0, bus.ERRO}, {31'b0, merr});
    for (int i = 0; i < 4; i++) drive_row(1, 2, 3, 4);
    drain();
    check("t6_erro_unf", {31'b0, bus.ERRO}, {31'b0, merr});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
